// File: rtl/xrv_if_align_fifo.sv
// rtl/xrv_if_align_fifo.sv - instruction-fetch alignment buffer
// Aligned 32-bit fetch words in, halfword-aligned instructions out at bit 0.
module xrv_if_align_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        jmp,
  input  logic        jmp_addr_bit1,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty
);

  localparam int CAP = 2 * DEPTH;
  localparam int PW  = $clog2(CAP);
  localparam int CW  = PW + 1;

  logic [15:0]   mem_q [CAP];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          skip_q, skip_d;

  logic [PW-1:0] rd_ptr_p1, wr_ptr_p1;
  logic [15:0]   h0, h1;
  logic [CW-1:0] need, wr_need, free;
  logic          wr_ok, rd_ok;

  assign rd_ptr_p1 = rd_ptr_q + PW'(1);
  assign wr_ptr_p1 = wr_ptr_q + PW'(1);
  assign h0        = mem_q[rd_ptr_q];
  assign h1        = mem_q[rd_ptr_p1];

  // Any low-bit pattern other than 2'b11 marks a 16-bit compressed instruction.
  assign need    = (h0[1:0] != 2'b11) ? CW'(1) : CW'(2);
  assign wr_need = skip_q ? CW'(1) : CW'(2);
  assign free    = CW'(CAP) - count_q;

  assign empty = (count_q < need);
  assign full  = (count_q > CW'(CAP - 4));

  always_comb begin
    rd_data = 32'h0;
    if (count_q == CW'(1)) begin
      rd_data = {16'h0, h0};
    end else if (count_q != '0) begin
      rd_data = {h1, h0};
    end
  end

  assign wr_ok = wr_en && !jmp && (free >= wr_need);
  assign rd_ok = rd_en && !jmp && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    skip_d   = skip_q;
    if (jmp) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      skip_d   = jmp_addr_bit1;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + PW'(wr_need);
        skip_d   = 1'b0;
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(need);
      end
      count_d = count_q + (wr_ok ? wr_need : CW'(0)) - (rd_ok ? need : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      skip_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      skip_q   <= skip_d;
    end
  end

  // Halfword-aligned jump targets drop the low half of the first fetched word.
  always_ff @(posedge clk) begin
    if (!rstb && wr_ok) begin
      if (skip_q) begin
        mem_q[wr_ptr_q] <= wr_data[31:16];
      end else begin
        mem_q[wr_ptr_q]  <= wr_data[15:0];
        mem_q[wr_ptr_p1] <= wr_data[31:16];
      end
    end
  end

endmodule

// File: doc/xrv_if_align_fifo.md
# xrv_if_align_fifo

Instruction-fetch alignment buffer between the instruction-memory read port and the fetch/decompress stage of the xrv core. It accepts aligned 32-bit fetch words, stores them as a circular queue of 16-bit halfwords, and always presents the next instruction, compressed or not, starting at bit 0 of `rd_data`. A jump flushes the queue and can discard the first halfword for halfword-aligned targets. `full` and `empty` drive the fetcher's request throttling and read enable.

## Interface
- `DEPTH`, 4, capacity in 32-bit words; power of two, ≥2; halfword capacity `CAP = 2*DEPTH`
- `clk`  in  1  core clock
- `rstb`  in  1  reset; synchronous, active-high (asserted = 1)
- `jmp`  in  1  flush request; the next accepted write is the word containing the jump target
- `jmp_addr_bit1`  in  1  bit 1 of the jump target, sampled when `jmp`=1
- `wr_data`  in  32  fetched word; little-endian halfwords, `[15:0]` first
- `wr_en`  in  1  push `wr_data`
- `rd_en`  in  1  pop the instruction currently on `rd_data`
- `rd_data`  out  32  head instruction, aligned to bit 0
- `full`  out  1  fewer than 2 words of free space
- `empty`  out  1  no complete instruction available

## Operation
- Storage: `CAP` × 16-bit halfword array with `wr_ptr`, `rd_ptr` (log2(CAP) bits, wrap modulo CAP) and `count` (log2(CAP)+1 bits). The array is not reset; pointers, `count` and `skip` are.
- Head: `h0 = mem[rd_ptr]`, `h1 = mem[rd_ptr+1]`. The instruction is compressed when `h0[1:0] != 2'b11`; `need` is 1 if compressed, else 2.
- `rd_data`: 0 when `count`=0; `{16'h0,h0}` when `count`=1; `{h1,h0}` otherwise. Consumers use only `[15:0]` when compressed.
- `empty = (count < need)`, so a split 32-bit instruction with only its low half present reads as empty. `full = (count > CAP-4)`.
- Write (`wr_en`=1, `jmp`=0):
  - `skip`=0: store both halfwords at `wr_ptr` and `wr_ptr+1`; `wr_ptr`+=2; `count`+=2.
  - `skip`=1: store only `wr_data[31:16]`; `wr_ptr`+=1; `count`+=1; clear `skip`.
  - If free space is below the halfwords needed, the write is dropped with no state change. This is a protocol violation.
- Read (`rd_en`=1, `empty`=0, `jmp`=0): `rd_ptr += need`; `count -= need`. `rd_en` while empty is ignored.
- Same-cycle read and write: both take effect; `count` changes by (written − popped).
- `jmp`=1: `wr_ptr`, `rd_ptr` and `count` go to 0 and `skip` is set to `jmp_addr_bit1`. Any same-cycle `wr_en` and `rd_en` are ignored. `jmp` has priority over everything except reset.
- Reset has priority over all inputs: pointers, `count` and `skip` go to 0.

## Timing
- Reset values: `empty`=1, `full`=0, `rd_data`=0.
- `rd_data`, `empty` and `full` are combinational from registered state, with zero input-to-output combinational paths. A write at edge N is readable in cycle N+1.
- Write latency for `full`: the producer samples `full` one cycle before the corresponding `wr_en`. The `CAP-4` threshold therefore absorbs one in-flight word plus the current one, so no overflow occurs under this protocol.
- Jump recovery: the producer's first post-jump `wr_en` arrives 2 cycles after `jmp` at the earliest. `empty` stays 1 from the cycle after `jmp` until that write lands.
- Throughput: one instruction per cycle whenever `empty`=0, including back-to-back instructions that straddle a word boundary.

## Test plan
- Reset: hold `rstb`=1 for 2 cycles, with `wr_en` asserted in the same cycles -> `empty`=1, `full`=0, `rd_data`=0 after release; no data stored.
- Uncompressed instruction: write 32'h00130513 -> next cycle `rd_data`=32'h00130513 and `empty`=0. Then `rd_en` -> `empty`=1, `count`=0.
- Mixed stream:
  - Write 32'h05134501 -> `rd_data`=32'h05134501.
  - `rd_en` -> `empty`=1 (split instruction, `count`=1).
  - Write 32'h45850013 -> `rd_data`=32'h00130513.
  - `rd_en` -> `rd_data`=32'h00004585.
  - `rd_en` -> `empty`=1.
- Halfword jump: `jmp`=1 with `jmp_addr_bit1`=1, then 2 cycles later write 32'h45850001 -> `rd_data`=32'h00004585, `count`=1. A second write of 32'h00010001 lands at `h1`.
- Full/wrap (`DEPTH`=4):
  - Push words with no reads -> `full`=1 once `count`=6.
  - The in-flight write is accepted -> `count`=8.
  - An extra `wr_en` is dropped.
  - Drain 8 compressed halfwords -> pointers wrap and data order is preserved.
- Flush collision: with `count`=4, assert `jmp`, `wr_en` and `rd_en` in one cycle -> next cycle `count`=0, `empty`=1, and nothing from that cycle's write is stored.
